// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered column/row position with valid, sync and start pulses.
// Define VGA_FRAME_CNT_EN to build the 8-bit completed-frame counter; otherwise frame_count is tied to zero.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10
) (
  input  logic          vga_clock,
  input  logic          rst_n_i,
  input  logic          enable,
  output logic [CW-1:0] vga_col,
  output logic [CW-1:0] vga_row,
  output logic          vga_valid,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
  end

  logic          col_wrap;
  logic          row_wrap;
  logic [CW-1:0] col_next;
  logic [CW-1:0] row_next;

  // Decode attributes from the next position so every output lines up with the counters.
  always_comb begin
    col_wrap = (vga_col == H_LAST);
    row_wrap = (vga_row == V_LAST);
    col_next = col_wrap ? '0 : vga_col + ONE;
    row_next = vga_row;
    if (col_wrap) begin
      row_next = row_wrap ? '0 : vga_row + ONE;
    end
  end

  // Reset parks on the last position so the first enabled edge presents (0,0) with fresh pulses.
  always_ff @(posedge vga_clock or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vga_col     <= H_LAST;
      vga_row     <= V_LAST;
      vga_valid   <= 1'b0;
      h_sync      <= ~HSYNC_POL;
      v_sync      <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      vga_col     <= col_next;
      vga_row     <= row_next;
      vga_valid   <= (int'(col_next) < H_ACTIVE) && (int'(row_next) < V_ACTIVE);
      h_sync      <= (int'(col_next) >= HS_START && int'(col_next) < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      v_sync      <= (int'(row_next) >= VS_START && int'(row_next) < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      line_start  <= (col_next == '0);
      frame_start <= (col_next == '0) && (row_next == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Counts on the same edge that presents (0,0), wrapping naturally at 8 bits.
  always_ff @(posedge vga_clock or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_q <= 8'd0;
    end else if (enable && col_wrap && row_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule
